// File: rtl/reg_scan_unit.sv
// Streams a contiguous (wrapping) range of register-file words out over a valid/ready port.
// Optional macro REG_SCAN_CHECKSUM_EN appends a modular-sum word after the final register word.
module reg_scan_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
`ifdef REG_SCAN_CHECKSUM_EN
    S_SUM,
`endif
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;
`ifdef REG_SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif

  logic w_accept;
  logic w_final;

  assign w_accept = r_out_valid && out_ready;
  assign w_final  = (r_out_addr == r_last_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_addr <= '0;
      r_rd_addr   <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef REG_SCAN_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_last_addr <= last_addr;
            r_rd_addr   <= start_addr;
            r_busy      <= 1'b1;
`ifdef REG_SCAN_CHECKSUM_EN
            r_sum       <= '0;
`endif
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          r_out_data  <= rd_data;
          r_out_addr  <= r_rd_addr;
          r_out_valid <= 1'b1;
`ifdef REG_SCAN_CHECKSUM_EN
          r_out_last  <= 1'b0;
`else
          r_out_last  <= (r_rd_addr == r_last_addr);
`endif
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef REG_SCAN_CHECKSUM_EN
            r_sum       <= r_sum + r_out_data;
`endif
            if (w_final) begin
`ifdef REG_SCAN_CHECKSUM_EN
              // Sum word is formed directly from the running sum plus the word being accepted.
              r_out_data  <= r_sum + r_out_data;
              r_out_addr  <= '0;
              r_out_last  <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_SUM;
`else
              r_done      <= 1'b1;
              r_state     <= S_DONE;
`endif
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
              r_state   <= S_READ;
            end
          end
        end
`ifdef REG_SCAN_CHECKSUM_EN
        S_SUM: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_addr   = r_rd_addr;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_reg_scan_unit.sv
// Scoreboard bench for reg_scan_unit: expected words queued at start, popped on each accepted word.
module tb_reg_scan_unit;
  localparam int AW = 4;
  localparam int DW = 16;
`ifdef REG_SCAN_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [AW-1:0] start_addr, last_addr, rd_addr, out_addr;
  logic [DW-1:0] rd_data, out_data;
  logic          out_valid, out_last, busy, done;

  logic [DW-1:0] regs [16];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  reg_scan_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .last_addr(last_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  assign rd_data = regs[rd_addr];
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Words are accepted on the next rising edge; sample on the falling edge before it.
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_word", 1, 0);
      else begin
        e = sb.pop_front();
        check("word_addr", out_addr, e.a);
        check("word_data", out_data, e.d);
        check("word_last", out_last, e.l);
      end
    end
  end

  task automatic push_scan(input logic [AW-1:0] s, input logic [AW-1:0] l, output int n);
    logic [AW-1:0] diff, a;
    logic [DW-1:0] sum;
    exp_t e;
    diff = l - s;
    n = int'(diff) + 1;
    sum = '0;
    a = s;
    for (int i = 0; i < n; i++) begin
      e.a = a;
      e.d = regs[a];
      e.l = (EXTRA == 0) && (i == n - 1);
      sb.push_back(e);
      sum = sum + regs[a];
      a = a + 1'b1;
    end
    if (EXTRA != 0) begin
      e.a = '0;
      e.d = sum;
      e.l = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_addr"}, out_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run_scan(input logic [AW-1:0] s, input logic [AW-1:0] l);
    int n, c, d0;
    push_scan(s, l, n);
    d0 = done_cnt;
    out_ready = 1'b1;
    start_addr = s;
    last_addr = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    check("busy_after_start", busy, 1);
    while (!out_valid && c < 20) begin @(posedge clk); #1; c++; end
    check("first_valid_latency", c, 2);
    while (!done && c < 200) begin @(posedge clk); #1; c++; end
    check("scan_cycles", c, 2 * n + 1 + EXTRA);
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - d0, 1);
    check("sb_empty", sb.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int c, d0, n;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_a;

    for (int i = 0; i < 16; i++) regs[i] = DW'(16'h1000 + i);
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; start_addr = '0; last_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_scan(4'd3, 4'd5);
    check("rd_addr_hold", rd_addr, 5);
    run_scan(4'd14, 4'd1);
    run_scan(4'd7, 4'd7);

    // Backpressure on the second word, with an ignored start while busy.
    push_scan(4'd0, 4'd3, n);
    d0 = done_cnt;
    out_ready = 1'b0; start_addr = 4'd0; last_addr = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin @(posedge clk); #1; c++; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin @(posedge clk); #1; c++; end
    hold_d = out_data;
    hold_a = out_addr;
    check("stall_word_addr", hold_a, 1);
    start_addr = 4'd9; last_addr = 4'd12; start = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, hold_d);
      check("stall_addr", out_addr, hold_a);
    end
    out_ready = 1'b1;
    c = 0;
    while (!done && c < 50) begin @(posedge clk); #1; c++; end
    check("stall_done", done, 1);
    repeat (2) @(posedge clk);
    #1;
    check("stall_done_pulses", done_cnt - d0, 1);
    check("stall_sb_empty", sb.size(), 0);

    // Reset during the third SEND of a full scan aborts it.
    push_scan(4'd0, 4'd15, n);
    start_addr = 4'd0; last_addr = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!(out_valid && out_addr == 4'd2) && c < 100) begin @(posedge clk); #1; c++; end
    check("third_send_seen", out_valid && out_addr == 4'd2, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("abort");
    rst = 1'b0;
    sb.delete();
    d0 = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_valid", out_valid, 0);
    run_scan(4'd14, 4'd1);

    regs[0] = 16'h0001; regs[1] = 16'h0002; regs[2] = 16'h0003; regs[3] = 16'hFFFF;
    run_scan(4'd0, 4'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
